// File: rtl/serial_link_phy_ctrl.sv
// Serial link PHY TX controller. It arbitrates between control and payload
// requesters onto one PHY lane group and applies new PHY timing only while the
// link is quiet.
module serial_link_phy_ctrl #(
  parameter int NumLanes     = 8,
  parameter int EnDdr        = 1,
  parameter int MaxClkDiv    = 32,
  parameter int DefClkDiv    = 8,
  parameter int QuietCycles  = 4,
  parameter int MaxCtrlBurst = 4,
  localparam int PhyW        = NumLanes * (1 + EnDdr),
  localparam int CfgW        = $clog2(MaxClkDiv) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [PhyW-1:0] ctrl_data_i,
  input  logic            ctrl_valid_i,
  output logic            ctrl_ready_o,
  input  logic [PhyW-1:0] data_data_i,
  input  logic            data_valid_i,
  output logic            data_ready_o,
  input  logic [CfgW-1:0] cfg_clk_div_i,
  input  logic [CfgW-1:0] cfg_shift_start_i,
  input  logic [CfgW-1:0] cfg_shift_end_i,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  output logic            cfg_err_o,
  output logic [PhyW-1:0] phy_data_o,
  output logic            phy_valid_o,
  input  logic            phy_ready_i,
  output logic [CfgW-1:0] phy_clk_div_o,
  output logic [CfgW-1:0] phy_shift_start_o,
  output logic [CfgW-1:0] phy_shift_end_o,
  output logic            busy_o
);

  localparam int BurstW = $clog2(MaxCtrlBurst + 1);
  localparam int QcntW  = (QuietCycles > 1) ? $clog2(QuietCycles) : 1;
  localparam logic [CfgW-1:0]   MaxDiv   = CfgW'(MaxClkDiv);
  localparam logic [BurstW-1:0] MaxBurst = BurstW'(MaxCtrlBurst);
  localparam logic [QcntW-1:0]  QcntLast = QcntW'(QuietCycles - 1);

  typedef enum logic [1:0] {IDLE, SEND, QUIET, APPLY} state_e;

  state_e            state_q, state_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [QcntW-1:0]  qcnt_q, qcnt_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [PhyW-1:0]   data_q, data_d;
  logic [CfgW-1:0]   sh_div_q, sh_div_d, sh_start_q, sh_start_d, sh_end_q, sh_end_d;
  logic [CfgW-1:0]   div_q, div_d, start_q, start_d, end_q, end_d;

  logic cfg_ok, cfg_take, cfg_rej, can_grant, gnt_ctrl, gnt_data;

  // Config legality, and whether an offered config is latched or rejected.
  // A pending config masks further offers until it has been applied.
  always_comb begin
    cfg_ok   = (cfg_clk_div_i >= CfgW'(2)) && (cfg_clk_div_i <= MaxDiv) &&
               (cfg_shift_start_i < cfg_clk_div_i) && (cfg_shift_end_i < cfg_clk_div_i);
    cfg_take = cfg_valid_i && !pend_q && cfg_ok;
    cfg_rej  = cfg_valid_i && !pend_q && !cfg_ok;
  end

  // Arbitration: ctrl wins unless it has used up its burst while data waits.
  // A freshly latched config blocks the grant in the same cycle.
  always_comb begin
    can_grant = rst_ni && !pend_q && !cfg_take &&
                ((state_q == IDLE) || ((state_q == SEND) && phy_ready_i));
    gnt_ctrl  = can_grant && ctrl_valid_i && !(data_valid_i && (burst_q >= MaxBurst));
    gnt_data  = can_grant && data_valid_i && !gnt_ctrl;
  end

  // Next-state logic for the FSM, the flit register, the burst counter and the config shadow.
  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    pend_d     = pend_q;
    sh_div_d   = sh_div_q;
    sh_start_d = sh_start_q;
    sh_end_d   = sh_end_q;
    div_d      = div_q;
    start_d    = start_q;
    end_d      = end_q;
    burst_d    = burst_q;
    data_d     = data_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_ctrl || gnt_data) begin
          state_d = SEND;
        end else if (pend_q) begin
          state_d = QUIET;
          qcnt_d  = '0;
        end
      end
      SEND: begin
        if (phy_ready_i && !(gnt_ctrl || gnt_data)) state_d = IDLE;
      end
      QUIET: begin
        if (qcnt_q == QcntLast) state_d = APPLY;
        else                    qcnt_d  = qcnt_q + QcntW'(1);
      end
      APPLY: begin
        div_d   = sh_div_q;
        start_d = sh_start_q;
        end_d   = sh_end_q;
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cfg_take) begin
      pend_d     = 1'b1;
      sh_div_d   = cfg_clk_div_i;
      sh_start_d = cfg_shift_start_i;
      sh_end_d   = cfg_shift_end_i;
    end

    if (gnt_ctrl)      data_d = ctrl_data_i;
    else if (gnt_data) data_d = data_data_i;

    if (!data_valid_i || gnt_data)        burst_d = '0;
    else if (gnt_ctrl && burst_q < MaxBurst) burst_d = burst_q + BurstW'(1);

    valid_d = (state_d == SEND);
    err_d   = cfg_rej;
  end

  // State registers; timing outputs come up at their defaults.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      qcnt_q     <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      burst_q    <= '0;
      sh_div_q   <= '0;
      sh_start_q <= '0;
      sh_end_q   <= '0;
      div_q      <= CfgW'(DefClkDiv);
      start_q    <= '0;
      end_q      <= CfgW'(DefClkDiv / 2);
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      burst_q    <= burst_d;
      sh_div_q   <= sh_div_d;
      sh_start_q <= sh_start_d;
      sh_end_q   <= sh_end_d;
      div_q      <= div_d;
      start_q    <= start_d;
      end_q      <= end_d;
    end
  end

  assign ctrl_ready_o      = gnt_ctrl;
  assign data_ready_o      = gnt_data;
  assign phy_valid_o       = valid_q;
  assign phy_data_o        = data_q;
  assign cfg_err_o         = err_q;
  assign cfg_ready_o       = (state_q == APPLY) || err_q;
  assign phy_clk_div_o     = div_q;
  assign phy_shift_start_o = start_q;
  assign phy_shift_end_o   = end_q;
  assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_serial_link_phy_ctrl.sv
// Directed + randomized bench for serial_link_phy_ctrl with a transaction-level reference model.
module tb_serial_link_phy_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] ctrl_data_i = '0, data_data_i = '0, phy_data_o;
  logic        ctrl_valid_i = 1'b0, data_valid_i = 1'b0, ctrl_ready_o, data_ready_o;
  logic [5:0]  cfg_clk_div_i = '0, cfg_shift_start_i = '0, cfg_shift_end_i = '0;
  logic        cfg_valid_i = 1'b0, cfg_ready_o, cfg_err_o;
  logic        phy_valid_o, phy_ready_i = 1'b0, busy_o;
  logic [5:0]  phy_clk_div_o, phy_shift_start_o, phy_shift_end_o;

  int checks = 0;
  int errors = 0;

  // reference model: one outstanding flit on the link, ctrl streak count
  bit          m_busy = 1'b0;
  logic [15:0] m_data = '0;
  int          m_streak = 0;
  int          last_gnt = 0;
  int          glog[$];

  always #5 clk_i = ~clk_i;

  serial_link_phy_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ctrl_data_i(ctrl_data_i), .ctrl_valid_i(ctrl_valid_i), .ctrl_ready_o(ctrl_ready_o),
    .data_data_i(data_data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .cfg_clk_div_i(cfg_clk_div_i), .cfg_shift_start_i(cfg_shift_start_i),
    .cfg_shift_end_i(cfg_shift_end_i), .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o), .cfg_err_o(cfg_err_o),
    .phy_data_o(phy_data_o), .phy_valid_o(phy_valid_o), .phy_ready_i(phy_ready_i),
    .phy_clk_div_o(phy_clk_div_o), .phy_shift_start_o(phy_shift_start_o),
    .phy_shift_end_o(phy_shift_end_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [5:0] dv, input logic [5:0] s, input logic [5:0] e);
    cfg_clk_div_i = dv; cfg_shift_start_i = s; cfg_shift_end_i = e;
  endtask

  // One link cycle checked against the model. mode: 0 drop after grant,
  // 1 always valid with fresh data, 2 random sources.
  task automatic step(input bit pr, input int mode);
    bit can, gc, gd;
    phy_ready_i = pr;
    @(negedge clk_i);
    can = !m_busy || pr;
    gc  = can && ctrl_valid_i && !(data_valid_i && m_streak >= 4);
    gd  = can && data_valid_i && !gc;
    chk("phy_valid", 32'(phy_valid_o), 32'(m_busy));
    if (m_busy) chk("phy_data", 32'(phy_data_o), 32'(m_data));
    chk("ctrl_ready", 32'(ctrl_ready_o), 32'(gc));
    chk("data_ready", 32'(data_ready_o), 32'(gd));
    if (gc)      m_data = ctrl_data_i;
    else if (gd) m_data = data_data_i;
    m_busy = gc || gd || (m_busy && !pr);
    if (!data_valid_i || gd) m_streak = 0;
    else if (gc)             m_streak++;
    last_gnt = gc ? 1 : (gd ? 2 : 0);
    @(posedge clk_i); #1;
    case (mode)
      0: begin
        if (gc) ctrl_valid_i = 1'b0;
        if (gd) data_valid_i = 1'b0;
      end
      1: begin
        if (gc) ctrl_data_i = 16'($urandom);
        if (gd) data_data_i = 16'($urandom);
      end
      default: begin
        if (gc || !ctrl_valid_i) begin
          ctrl_valid_i = ($urandom_range(0, 1) == 1); ctrl_data_i = 16'($urandom);
        end
        if (gd || !data_valid_i) begin
          data_valid_i = ($urandom_range(0, 2) == 1); data_data_i = 16'($urandom);
        end
      end
    endcase
  endtask

  // Rejected config: exactly one err pulse with ready, timing untouched.
  task automatic cfg_bad(input logic [5:0] dv, input logic [5:0] s, input logic [5:0] e,
                         input logic [5:0] keep_div);
    int nerr, nrdy;
    nerr = 0; nrdy = 0;
    set_cfg(dv, s, e); cfg_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (cfg_err_o) nerr++;
      if (cfg_ready_o && cfg_err_o) nrdy++;
      @(posedge clk_i); #1;
      cfg_valid_i = 1'b0;
    end
    chk("bad_err_pulses", 32'(nerr), 32'd1);
    chk("bad_rdy_with_err", 32'(nrdy), 32'd1);
    chk("bad_div_kept", 32'(phy_clk_div_o), 32'(keep_div));
    chk("bad_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // reset values while held in reset
    #12;
    chk("rst_phy_valid", 32'(phy_valid_o), 32'd0);
    chk("rst_phy_data", 32'(phy_data_o), 32'd0);
    chk("rst_clk_div", 32'(phy_clk_div_o), 32'd8);
    chk("rst_shift_start", 32'(phy_shift_start_o), 32'd0);
    chk("rst_shift_end", 32'(phy_shift_end_o), 32'd4);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready_o), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // idle link after reset
    for (int i = 0; i < 6; i++) step(1'b0, 0);
    chk("idle_clk_div", 32'(phy_clk_div_o), 32'd8);
    chk("idle_shift_end", 32'(phy_shift_end_o), 32'd4);

    // single data flit held by PHY backpressure for 20 cycles
    data_data_i = 16'hABCD; data_valid_i = 1'b1;
    step(1'b0, 0);
    for (int i = 0; i < 20; i++) step(1'b0, 0);
    chk("hold_data", 32'(phy_data_o), 32'h0000ABCD);
    step(1'b1, 0);
    step(1'b0, 0);

    // both requesters always valid, PHY ready every 8th cycle
    ctrl_valid_i = 1'b1; ctrl_data_i = 16'h1111;
    data_valid_i = 1'b1; data_data_i = 16'h2222;
    glog.delete();
    for (int c = 0; c < 80; c++) begin
      step(c % 8 == 7, 1);
      if (last_gnt != 0) glog.push_back(last_gnt);
      if (c > 0) chk("burst_no_gap", 32'(phy_valid_o), 32'd1);
    end
    chk("burst_grant_count", 32'(glog.size()), 32'd11);
    foreach (glog[i]) chk("burst_pattern", 32'(glog[i]), (i % 5 == 4) ? 32'd2 : 32'd1);
    ctrl_valid_i = 1'b0; data_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) step(($urandom_range(0, 1) == 1), 2);
    ctrl_valid_i = 1'b0; data_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 0);

    // config arrives during SEND: flit completes, quiet gap, apply
    data_valid_i = 1'b1; data_data_i = 16'h1234;
    step(1'b0, 0); step(1'b0, 0);
    ctrl_valid_i = 1'b1; ctrl_data_i = 16'h0C0C;
    set_cfg(6'd16, 6'd0, 6'd8); cfg_valid_i = 1'b1; phy_ready_i = 1'b0;
    @(negedge clk_i);
    chk("c37_hold_valid", 32'(phy_valid_o), 32'd1);
    chk("c37_no_gnt_a", 32'(ctrl_ready_o), 32'd0);
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0; phy_ready_i = 1'b1;
    @(negedge clk_i);
    chk("c37_last_flit", 32'(phy_data_o), 32'h00001234);
    chk("c37_last_valid", 32'(phy_valid_o), 32'd1);
    chk("c37_no_gnt_b", 32'(ctrl_ready_o), 32'd0);
    @(posedge clk_i); #1;
    phy_ready_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) begin set_cfg(6'd2, 6'd0, 6'd1); cfg_valid_i = 1'b1; end
      @(negedge clk_i);
      chk("c37_quiet_valid", 32'(phy_valid_o), 32'd0);
      chk("c37_quiet_no_gnt", 32'(ctrl_ready_o), 32'd0);
      chk("c37_busy", 32'(busy_o), (k != 1) ? 32'd1 : 32'd0);
      chk("c37_cfg_ready", 32'(cfg_ready_o), (k == 6) ? 32'd1 : 32'd0);
      chk("c37_cfg_err", 32'(cfg_err_o), 32'd0);
      chk("c37_div_old", 32'(phy_clk_div_o), 32'd8);
      @(posedge clk_i); #1;
      cfg_valid_i = 1'b0;
    end
    m_busy = 1'b0; m_streak = 0;
    step(1'b1, 0);
    chk("c37_div_new", 32'(phy_clk_div_o), 32'd16);
    chk("c37_start_new", 32'(phy_shift_start_o), 32'd0);
    chk("c37_end_new", 32'(phy_shift_end_o), 32'd8);
    step(1'b1, 0); step(1'b1, 0);

    // config and requester together in IDLE: config wins (boundary-legal values)
    ctrl_valid_i = 1'b1; ctrl_data_i = 16'h7777;
    set_cfg(6'd32, 6'd31, 6'd31); cfg_valid_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk_i);
      chk("c30_no_gnt", 32'(ctrl_ready_o), 32'd0);
      chk("c30_valid_low", 32'(phy_valid_o), 32'd0);
      if (cfg_ready_o) seen = 1'b1;
      @(posedge clk_i); #1;
      cfg_valid_i = 1'b0;
    end
    chk("c30_applied_in_time", 32'(seen), 32'd1);
    m_busy = 1'b0; m_streak = 0;
    step(1'b1, 0);
    chk("c30_div", 32'(phy_clk_div_o), 32'd32);
    chk("c30_start", 32'(phy_shift_start_o), 32'd31);
    chk("c30_end", 32'(phy_shift_end_o), 32'd31);
    step(1'b1, 0); step(1'b1, 0);

    // rejected configs
    cfg_bad(6'd4, 6'd4, 6'd2, 6'd32);
    cfg_bad(6'd1, 6'd0, 6'd0, 6'd32);
    cfg_bad(6'd33, 6'd0, 6'd0, 6'd32);
    cfg_bad(6'd8, 6'd0, 6'd8, 6'd32);
    chk("bad_start_kept", 32'(phy_shift_start_o), 32'd31);

    // traffic still flows normally after rejects
    for (int i = 0; i < 100; i++) step(($urandom_range(0, 1) == 1), 2);
    ctrl_valid_i = 1'b0; data_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 0);

    // reset in the middle of SEND drops the flit
    data_valid_i = 1'b1; data_data_i = 16'h5A5A;
    step(1'b0, 0);
    chk("mid_send_valid", 32'(phy_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(phy_valid_o), 32'd0);
    chk("mid_rst_data", 32'(phy_data_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_div", 32'(phy_clk_div_o), 32'd8);
    chk("mid_rst_end", 32'(phy_shift_end_o), 32'd4);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    m_busy = 1'b0; m_streak = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_link_phy_ctrl.md
SERIAL_LINK_PHY_CTRL -- requirements
Module: serial_link_phy_ctrl

Interface
REQ-001 SHALL have parameter NumLanes, default 8, lanes per channel.
REQ-002 SHALL have parameter EnDdr, default 1, DDR mode; PhyW = NumLanes*(1+EnDdr).
REQ-003 SHALL have parameter MaxClkDiv, default 32; CfgW = $clog2(MaxClkDiv)+1.
REQ-004 SHALL have parameter DefClkDiv, default 8, divider applied at reset.
REQ-005 SHALL have parameter QuietCycles, default 4, idle cycles before applying a new config.
REQ-006 SHALL have parameter MaxCtrlBurst, default 4, consecutive ctrl grants allowed while data waits.
REQ-007 clk_i  in  1  system clock.
REQ-008 rst_ni  in  1  reset, asynchronous, active-low.
REQ-009 ctrl_data_i / ctrl_valid_i / ctrl_ready_o  in/in/out  PhyW/1/1  control-flit requester (credits).
REQ-010 data_data_i / data_valid_i / data_ready_o  in/in/out  PhyW/1/1  payload requester.
REQ-011 cfg_clk_div_i, cfg_shift_start_i, cfg_shift_end_i  in  CfgW each  requested PHY timing.
REQ-012 cfg_valid_i / cfg_ready_o / cfg_err_o  in/out/out  1 each  config handshake, reject pulse.
REQ-013 phy_data_o / phy_valid_o / phy_ready_i  out/out/in  PhyW/1/1  to PHY TX.
REQ-014 phy_clk_div_o, phy_shift_start_o, phy_shift_end_o  out  CfgW each  applied PHY timing.
REQ-015 busy_o  out  1  high when FSM not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SEND, QUIET, APPLY.
REQ-017 IDLE, no cfg pending, any requester valid: SHALL grant one (its ready high same cycle), capture its data into phy_data_o, go SEND; phy_valid_o high next cycle.
REQ-018 Arbitration SHALL favour ctrl, except after MaxCtrlBurst consecutive ctrl grants with data_valid_i high, when the next grant SHALL go to data.
REQ-019 Burst counter SHALL clear on any data grant or any cycle data_valid_i is low.
REQ-020 SEND: phy_valid_o and phy_data_o SHALL stay stable until phy_ready_i.
REQ-021 SEND with phy_ready_i, a requester valid, no cfg pending: SHALL grant and capture same cycle, stay SEND, phy_valid_o continuously high (no clock-gating gap).
REQ-022 SEND with phy_ready_i otherwise: SHALL go IDLE, phy_valid_o low next cycle.
REQ-023 Both requester readies SHALL never be high in one cycle; neither SHALL be high outside IDLE/SEND-with-phy_ready_i.
REQ-024 cfg_valid_i SHALL be latched into a shadow register as pending; pending blocks new grants; current transfer completes.
REQ-025 Config invalid if clk_div < 2, clk_div > MaxClkDiv, shift_start >= clk_div or shift_end >= clk_div: SHALL pulse cfg_err_o and cfg_ready_o one cycle, discard, no FSM change.
REQ-026 Valid pending config with FSM IDLE: SHALL go QUIET, count QuietCycles cycles with phy_valid_o low, then APPLY.
REQ-027 APPLY (one cycle): SHALL load phy_* timing outputs from shadow, pulse cfg_ready_o, return IDLE.
REQ-028 cfg_valid_i while cfg pending SHALL be ignored until cfg_ready_o pulses.
REQ-029 phy_* timing outputs SHALL change only in APPLY or reset.
REQ-030 Simultaneous cfg_valid_i and requester valid in IDLE: config SHALL win; no grant.

Reset
REQ-031 Asynchronous reset SHALL force IDLE, phy_valid_o=0, phy_data_o=0, readies=0, cfg_ready_o=0, cfg_err_o=0, busy_o=0, burst counter=0, pending cleared.
REQ-032 Reset SHALL set phy_clk_div_o=DefClkDiv, phy_shift_start_o=0, phy_shift_end_o=DefClkDiv/2.
REQ-033 Reset mid-SEND SHALL drop the flit without completing handshake.

Verification
REQ-034 Reset release, no stimulus -> phy_clk_div_o=8, shift_start=0, shift_end=4, phy_valid_o=0 indefinitely.
REQ-035 Ctrl and data both continuously valid, phy_ready_i every 8th cycle -> grant pattern C,C,C,C,D repeating; phy_valid_o never drops.
REQ-036 Single data flit 0xABCD, phy_ready_i held low 20 cycles -> phy_data_o stable 0xABCD, phy_valid_o high all 20 cycles.
REQ-037 cfg {div=16,start=0,end=8} during SEND -> flit completes, then 4 cycles phy_valid_o low, APPLY, cfg_ready_o pulse, phy_clk_div_o=16.
REQ-038 cfg {div=4,start=4,end=2} -> cfg_err_o pulse, outputs unchanged, subsequent flits granted normally.
